// File: rtl/audio_i2s_tx_if.sv
// Sample-pair handshake between a PCM producer and the I2S transmitter.
// Handshake: a pair transfers on a clock edge where SAMPLE_VALID and
// SAMPLE_READY are both high; the producer holds SAMPLE_L/SAMPLE_R stable
// and may keep SAMPLE_VALID high until that edge. SAMPLE_READY depends only
// on registered state inside the consumer.
interface audio_i2s_tx_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] SAMPLE_L;
    logic [DATA_W-1:0] SAMPLE_R;
    logic              SAMPLE_VALID;
    logic              SAMPLE_READY;

    modport master (
        output SAMPLE_L,
        output SAMPLE_R,
        output SAMPLE_VALID,
        input  SAMPLE_READY
    );

    modport slave (
        input  SAMPLE_L,
        input  SAMPLE_R,
        input  SAMPLE_VALID,
        output SAMPLE_READY
    );
endinterface

// File: rtl/audio_i2s_tx.sv
// I2S / left-justified serial audio transmitter. BCK, LRCK and SDATA are
// flop outputs derived from CLK through a half-period counter; LRCK and
// SDATA only change on BCK falling events. One stereo pair is buffered.
module audio_i2s_tx #(
    parameter int DATA_W   = 16,
    parameter int HALF_BCK = 2,
    parameter int FMT_LJ   = 0
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic ENABLE,
    audio_i2s_tx_if.slave s_if,
    output logic I2S_BCK,
    output logic I2S_LRCK,
    output logic I2S_SDATA,
    output logic UNDERRUN
);
    localparam int SLOTS = 2 * DATA_W;
    localparam int SW    = $clog2(SLOTS);
    localparam int HW    = (HALF_BCK > 1) ? $clog2(HALF_BCK) : 1;
    localparam bit LJ    = (FMT_LJ != 0);

    logic [HW-1:0]     r_hcnt;
    logic              r_bck;
    logic [SW-1:0]     r_slot;
    logic              r_lrck;
    logic              r_sdata;
    logic              r_underrun;
    logic [SLOTS-1:0]  r_shift;
    logic              r_dly;
    logic              r_buf_full;
    logic [DATA_W-1:0] r_buf_l;
    logic [DATA_W-1:0] r_buf_r;

    logic              w_term;
    logic              w_fall;
    logic              w_frame;
    logic [SLOTS-1:0]  w_word;
    logic              w_lj_bit;
    logic [SW-1:0]     w_slot_nx;
    logic              w_lr_lj;
    logic              w_lr_i2s;

    assign w_term    = (r_hcnt == HW'(HALF_BCK - 1));
    // A falling event is the terminal count while BCK is currently high.
    assign w_fall    = ENABLE && w_term && r_bck;
    assign w_frame   = w_fall && (r_slot == '0);
    // An empty buffer at frame start sends a silent frame.
    assign w_word    = r_buf_full ? {r_buf_l, r_buf_r} : '0;
    assign w_lj_bit  = w_frame ? w_word[SLOTS-1] : r_shift[SLOTS-1];
    assign w_slot_nx = (r_slot == SW'(SLOTS - 1)) ? '0 : r_slot + 1'b1;
    assign w_lr_lj   = (r_slot >= SW'(DATA_W));
    // In I2S framing LRCK leads the data by one slot.
    assign w_lr_i2s  = (w_slot_nx >= SW'(DATA_W));

    assign s_if.SAMPLE_READY = !r_buf_full;
    assign I2S_BCK   = r_bck;
    assign I2S_LRCK  = r_lrck;
    assign I2S_SDATA = r_sdata;
    assign UNDERRUN  = r_underrun;

    // Bit-clock generation, slot sequencing and serial shifting.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_hcnt     <= '0;
            r_bck      <= 1'b0;
            r_slot     <= '0;
            r_lrck     <= 1'b0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
            r_shift    <= '0;
            r_dly      <= 1'b0;
        end else if (!ENABLE) begin
            r_hcnt     <= '0;
            r_bck      <= 1'b0;
            r_slot     <= '0;
            r_lrck     <= 1'b0;
            r_sdata    <= 1'b0;
            r_underrun <= 1'b0;
            r_shift    <= '0;
            r_dly      <= 1'b0;
        end else begin
            r_underrun <= w_frame && !r_buf_full;
            if (w_term) begin
                r_hcnt <= '0;
                r_bck  <= !r_bck;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
            if (w_fall) begin
                r_slot  <= w_slot_nx;
                r_lrck  <= LJ ? w_lr_lj : w_lr_i2s;
                r_sdata <= LJ ? w_lj_bit : r_dly;
                r_dly   <= w_lj_bit;
                r_shift <= w_frame ? (w_word << 1) : (r_shift << 1);
            end
        end
    end

    // One-pair buffer: frame start drains it, a handshake fills it.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_buf_full <= 1'b0;
            r_buf_l    <= '0;
            r_buf_r    <= '0;
        end else if (w_frame && r_buf_full) begin
            r_buf_full <= 1'b0;
        end else if (s_if.SAMPLE_VALID && !r_buf_full) begin
            r_buf_full <= 1'b1;
            r_buf_l    <= s_if.SAMPLE_L;
            r_buf_r    <= s_if.SAMPLE_R;
        end
    end
endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Serial audio transmitter on the consumer side of the audio clocking.
- Accepts stereo PCM sample pairs over a valid/ready handshake and buffers one pair.
- Generates bit clock (BCK), word clock (LRCK) and serial data for an external DAC, in I2S or left-justified framing.
- All outputs are registered and derived from one system clock, with no generated clock nets.

Parameters:
- DATA_W, 16: bits per channel. 2*DATA_W slots per frame. Legal range 8..32.
- HALF_BCK, 2: CLK cycles per BCK half period. Must be ≥1.
- FMT_LJ, 0: framing select. 0 = I2S (one-slot data delay). 1 = left-justified.

Ports:
- CLK  in  1  system clock, single clock domain.
- RESET_n  in  1  asynchronous active-low reset.
- ENABLE  in  1  run serializer. Low = outputs idle.
- SAMPLE_L  in  DATA_W  left sample, two's complement.
- SAMPLE_R  in  DATA_W  right sample, two's complement.
- SAMPLE_VALID  in  1  sample pair offered.
- SAMPLE_READY  out  1  buffer empty, pair will be accepted.
- I2S_BCK  out  1  bit clock.
- I2S_LRCK  out  1  word clock. 0 = left, 1 = right.
- I2S_SDATA  out  1  serial data, MSB first.
- UNDERRUN  out  1  one-CLK pulse when a frame starts with no buffered pair.

Behaviour:
- Interface: one clock CLK; reset RESET_n is asynchronous, active-low.
- Reset values: I2S_BCK=0, I2S_LRCK=0, I2S_SDATA=0, UNDERRUN=0. Buffer empty, so SAMPLE_READY=1. Counters and shift register cleared.
- Handshake:
  - SAMPLE_READY = !buf_full, computed from registered state only.
  - Transfer occurs on a CLK edge where VALID && READY. That edge captures L and R and sets buf_full.
  - VALID may stay high. Data must be held stable until the transfer.
- BCK timing:
  - Half-period counter counts 0..HALF_BCK-1 while ENABLE=1.
  - At terminal count, I2S_BCK toggles.
  - A cycle where BCK toggles 1→0 is a "falling event". All LRCK/SDATA updates happen only on falling events.
- Slot counter: slot 0..2*DATA_W-1, advances on each falling event and wraps to 0.
  - Frame start F = falling event with slot=0.
  - The first falling event after ENABLE rises is slot 0.
- Load at F:
  - If buf_full: shift register <= {L,R} and buf_full clears.
  - Else: shift register <= 0 and UNDERRUN=1 for that one CLK cycle.
  - If buf_full and VALID are both high at F, no accept happens that cycle. READY rises the next cycle.
- Left-justified mode (FMT_LJ=1):
  - At slot k, SDATA = bit (2*DATA_W-1-k) of {L,R}.
  - LRCK = (k >= DATA_W).
- I2S mode (FMT_LJ=0):
  - SDATA at slot k = the LJ bit of slot k-1. At slot 0 this is the previous frame's R LSB (0 after reset, enable or underrun).
  - LRCK = ((k+1) mod 2*DATA_W) >= DATA_W, i.e. LRCK leads data by one slot.
- Latency: a pair accepted with an empty buffer drives its L MSB at the next F (LJ) or one slot after F (I2S).
- Sustained rate: exactly one pair consumed per 4*DATA_W*HALF_BCK CLK cycles.
- ENABLE deassert, any time:
  - Next cycle: BCK, LRCK, SDATA = 0. Counters, shift register and I2S delay bit cleared.
  - Buffer content kept and handshake still active.
  - Re-enable starts a fresh frame.
- Reset mid-frame: all state clears immediately, including a full buffer. An in-flight pair is discarded.
- Output hazard: no glitches. Every output comes straight from a flop.

Test Plan:
- Reset: RESET_n=0 for 5 CLK with ENABLE=1 and VALID=1 → all serial outputs 0, UNDERRUN=0, READY=1. After release the pair is accepted on the first edge and READY=0.
- LJ framing (DATA_W=16, HALF_BCK=2, FMT_LJ=1): push L=16'hA5C3, R=16'h0F01, then ENABLE=1.
  - BCK period 4 CLK, frame 128 CLK.
  - SDATA slots 0..31 = A5C30F01 MSB-first.
  - LRCK=0 in slots 0..15 and 1 in slots 16..31.
- I2S framing (FMT_LJ=0), same data:
  - Slot 0 SDATA=0; slots 1..32 carry A5C30F01.
  - LRCK=1 in slots 15..30.
  - Next frame's slot 0 SDATA=1 (the R LSB).
- Underrun: one pair pushed, then none.
  - Second frame SDATA=0 in all slots, UNDERRUN pulses exactly one CLK at that F.
  - A pair pushed mid-frame appears in the third frame.
- Back-pressure: VALID held high with 3 distinct pairs queued by the bench.
  - Pair 1 accepted at cycle 0; pair 2 accepted the cycle after the first F.
  - Accepts are spaced 128 CLK apart; no pair is dropped or duplicated.
- Mid-frame disruption:
  - ENABLE=0 at slot 7 → outputs 0 next cycle, buffered pair retained. Re-enable → frame restarts at slot 0 with that pair.
  - Repeat with RESET_n pulse → outputs 0 asynchronously, READY=1, buffer empty.
